// File: rtl/branch_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_ctrl_pkg
// Description : Shared types and helpers for the fetch redirect controller.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        DRAIN = 2'd2
    } redirect_state_e;

    // Low target bits that must be clear when only 4-byte instructions exist.
    localparam logic [1:0] C_ALIGN_MASK = 2'b10;

    function automatic logic is_misaligned(input logic [1:0] low_bits, input logic c_ext);
        return !c_ext && ((low_bits & C_ALIGN_MASK) != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_outstanding_cnt.sv
`default_nettype none
// ============================================================================
// Module      : fetch_outstanding_cnt
// Description : Saturating up/down counter of in-flight imem requests.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_outstanding_cnt #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             below_max
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_dec_ok;
    logic             w_inc_ok;

    // A response with nothing in flight is ignored; a fire at full only counts
    // when a response retires an entry in the same cycle.
    assign w_dec_ok = dec && (r_count != '0);
    assign w_inc_ok = inc && ((r_count != C_MAX) || w_dec_ok);

    always_comb begin
        w_count_nxt = r_count;
        if (w_inc_ok && !w_dec_ok) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_inc_ok && w_dec_ok) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign count     = r_count;
    assign below_max = (r_count < C_MAX);

    a_no_fire_when_full : assert property (@(posedge clk) disable iff (rst)
        !(inc && !dec && (r_count == C_MAX)))
        else $error("fetch_outstanding_cnt: imem request fired with counter full");

    a_no_rsp_when_empty : assert property (@(posedge clk) disable iff (rst)
        !(dec && (r_count == '0)))
        else $error("fetch_outstanding_cnt: imem response with nothing outstanding");

endmodule
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_ctrl
// Description : Arbitrates branch/trap redirects into fetch and drops stale
//               imem responses from the abandoned path.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int C_EXT           = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ex_valid_i,
    input  logic            ex_branch_taken_i,
    input  logic [XLEN-1:0] ex_pc_branch_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_pc_i,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            redirect_ready_i,
    output logic            flush_if_o,
    output logic            flush_id_o,
    output logic            misalign_o,
    input  logic            imem_req_fire_i,
    input  logic            imem_rsp_valid_i,
    output logic            rsp_drop_o,
    output logic            fetch_allow_o,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    redirect_state_e  r_state;
    redirect_state_e  w_state_nxt;
    logic [XLEN-1:0]  r_pend_pc;
    logic [XLEN-1:0]  w_pend_pc_nxt;
    logic [CNT_W-1:0] r_kill_cnt;
    logic [CNT_W-1:0] w_kill_cnt_nxt;
    logic [CNT_W-1:0] w_kill_load;
    logic [CNT_W-1:0] w_outstanding;
    logic             r_misalign;
    logic             w_misalign_nxt;
    logic             w_below_max;
    logic             w_req_trap;
    logic             w_req_br;
    logic             w_br_bad;
    logic             w_new_req;
    logic [XLEN-1:0]  w_new_pc;

    fetch_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_outstanding (
        .clk       (clk_i),
        .rst       (rst_i),
        .inc       (imem_req_fire_i),
        .dec       (imem_rsp_valid_i),
        .count     (w_outstanding),
        .below_max (w_below_max)
    );

    assign w_req_trap = trap_valid_i;
    assign w_req_br   = ex_valid_i & ex_branch_taken_i;
    assign w_br_bad   = w_req_br & ~w_req_trap
                      & is_misaligned(ex_pc_branch_i[1:0], C_EXT != 0);
    assign w_new_req  = w_req_trap | (w_req_br & ~w_br_bad);
    assign w_new_pc   = w_req_trap ? trap_pc_i : ex_pc_branch_i;

    // Responses arriving in the accept cycle retire old-path requests already.
    assign w_kill_load = (imem_rsp_valid_i && (w_outstanding != '0))
                       ? w_outstanding - CNT_W'(1) : w_outstanding;

    always_comb begin
        w_state_nxt    = r_state;
        w_pend_pc_nxt  = r_pend_pc;
        w_kill_cnt_nxt = r_kill_cnt;
        w_misalign_nxt = 1'b0;
        case (r_state)
            PEND: begin
                if (redirect_ready_i) begin
                    w_kill_cnt_nxt = w_kill_load;
                    w_state_nxt    = (w_kill_load != '0) ? DRAIN : IDLE;
                end
                // A trap in the accept cycle starts a fresh redirect.
                if (w_req_trap) begin
                    w_pend_pc_nxt = trap_pc_i;
                    w_state_nxt   = PEND;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid_i && (r_kill_cnt != '0)) begin
                    w_kill_cnt_nxt = r_kill_cnt - CNT_W'(1);
                    if (r_kill_cnt == CNT_W'(1)) begin
                        w_state_nxt = IDLE;
                    end
                end else if (r_kill_cnt == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (r_state != PEND) begin
            w_misalign_nxt = w_br_bad;
            if (w_new_req) begin
                w_state_nxt   = PEND;
                w_pend_pc_nxt = w_new_pc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_pend_pc  <= '0;
            r_kill_cnt <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
            r_kill_cnt <= w_kill_cnt_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    assign redirect_valid_o = (r_state == PEND);
    assign redirect_pc_o    = {r_pend_pc[XLEN-1:1], 1'b0};
    assign flush_if_o       = (r_state == PEND);
    assign flush_id_o       = (r_state == PEND);
    assign misalign_o       = r_misalign;
    assign rsp_drop_o       = imem_rsp_valid_i
                            & ((r_state == PEND) | ((r_state == DRAIN) & (r_kill_cnt != '0)));
    assign fetch_allow_o    = w_below_max & (r_state != PEND);
    assign busy_o           = (r_state != IDLE);

endmodule
`default_nettype wire
